rat: RTL and testbench



---
 rtl/rat.sv | 92 +++++++++
 tb/tb_rat.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat.sv
// Register alias table: maps each GPR to the ROB tag of its youngest
// in-flight producer, with rename, commit release and full flush.
module rat #(
  parameter int ROB_DEPTH      = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int GPR_NUM        = 32,
  localparam int TW            = $clog2(ROB_DEPTH),
  localparam int CW            = GPR_ADDR_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      allocate_en,
  input  logic [TW-1:0]             rob_alloc_tag_2rat,
  input  logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
  input  logic                      rob_alloc_dst_wen_2rat,
  input  logic                      commit_en,
  input  logic [TW-1:0]             rob_commit_tag,
  input  logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
  input  logic                      rob_commit_br_taken,
  input  logic                      rob_commit_exp_en,
  input  logic [GPR_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [GPR_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_rat_valid,
  output logic [TW-1:0]             rs1_Paddr,
  output logic                      rs2_rat_valid,
  output logic [TW-1:0]             rs2_Paddr,
  output logic                      rat_flush,
  output logic [CW-1:0]             live_count
);

  logic [GPR_NUM-1:0] map_valid;
  logic [TW-1:0]      map_tag [GPR_NUM];

  logic          flush;
  logic          rename;
  logic          rename_new;
  logic          release_hit;
  logic [CW-1:0] count_next;

  assign rs1_rat_valid = map_valid[rs1_addr];
  assign rs1_Paddr     = map_tag[rs1_addr];
  assign rs2_rat_valid = map_valid[rs2_addr];
  assign rs2_Paddr     = map_tag[rs2_addr];

  assign flush = commit_en &
                 (rob_commit_br_taken | rob_commit_exp_en);

  assign rename = allocate_en & rob_alloc_dst_wen_2rat &
                  (rob_alloc_dst_addr_2rat != '0);

  assign rename_new = rename &
                      ~map_valid[rob_alloc_dst_addr_2rat];

  // A rename of the same GPR overrides its release.
  always_comb begin
    release_hit = commit_en &
                  map_valid[rob_commit_dst_addr_2rat] &
                  (map_tag[rob_commit_dst_addr_2rat] == rob_commit_tag);
    if (rename &&
        rob_alloc_dst_addr_2rat == rob_commit_dst_addr_2rat)
      release_hit = 1'b0;
  end

  assign count_next = live_count
                    + CW'(rename_new)
                    - CW'(release_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      map_valid  <= '0;
      rat_flush  <= 1'b0;
      live_count <= '0;
      for (int i = 0; i < GPR_NUM; i++)
        map_tag[i] <= '0;
    end else begin
      rat_flush <= flush;
      if (flush) begin
        map_valid  <= '0;
        live_count <= '0;
      end else begin
        if (release_hit)
          map_valid[rob_commit_dst_addr_2rat] <= 1'b0;
        if (rename) begin
          map_valid[rob_alloc_dst_addr_2rat] <= 1'b1;
          map_tag[rob_alloc_dst_addr_2rat]   <= rob_alloc_tag_2rat;
        end
        live_count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_rat.sv
// Bench for rat: directed scenarios with literal expectations plus
// random traffic checked every cycle against a table model.
module tb_rat;

  logic       clk = 1'b0;
  logic       rst;
  logic       allocate_en;
  logic [4:0] rob_alloc_tag_2rat;
  logic [4:0] rob_alloc_dst_addr_2rat;
  logic       rob_alloc_dst_wen_2rat;
  logic       commit_en;
  logic [4:0] rob_commit_tag;
  logic [4:0] rob_commit_dst_addr_2rat;
  logic       rob_commit_br_taken;
  logic       rob_commit_exp_en;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       rs1_rat_valid;
  logic [4:0] rs1_Paddr;
  logic       rs2_rat_valid;
  logic [4:0] rs2_Paddr;
  logic       rat_flush;
  logic [5:0] live_count;

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  bit m_valid [32];
  int m_tag   [32];
  bit m_flush;

  always #5 clk = ~clk;

  rat dut (
    .clk                      (clk),
    .rst                      (rst),
    .allocate_en              (allocate_en),
    .rob_alloc_tag_2rat       (rob_alloc_tag_2rat),
    .rob_alloc_dst_addr_2rat  (rob_alloc_dst_addr_2rat),
    .rob_alloc_dst_wen_2rat   (rob_alloc_dst_wen_2rat),
    .commit_en                (commit_en),
    .rob_commit_tag           (rob_commit_tag),
    .rob_commit_dst_addr_2rat (rob_commit_dst_addr_2rat),
    .rob_commit_br_taken      (rob_commit_br_taken),
    .rob_commit_exp_en        (rob_commit_exp_en),
    .rs1_addr                 (rs1_addr),
    .rs2_addr                 (rs2_addr),
    .rs1_rat_valid            (rs1_rat_valid),
    .rs1_Paddr                (rs1_Paddr),
    .rs2_rat_valid            (rs2_rat_valid),
    .rs2_Paddr                (rs2_Paddr),
    .rat_flush                (rat_flush),
    .live_count               (live_count)
  );

  function automatic int live_model();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model applies the table rules; release first so a same-GPR rename wins.
  task automatic model_edge();
    bit fl;
    int d;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_valid[i] = 0;
        m_tag[i] = 0;
      end
      m_flush = 0;
      return;
    end
    fl = commit_en && (rob_commit_br_taken || rob_commit_exp_en);
    m_flush = fl;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 0;
      return;
    end
    d = int'(rob_commit_dst_addr_2rat);
    if (commit_en && m_valid[d] && m_tag[d] == int'(rob_commit_tag))
      m_valid[d] = 0;
    if (allocate_en && rob_alloc_dst_wen_2rat && rob_alloc_dst_addr_2rat != 0) begin
      m_valid[rob_alloc_dst_addr_2rat] = 1;
      m_tag[rob_alloc_dst_addr_2rat] = int'(rob_alloc_tag_2rat);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0;
    allocate_en = 0;
    rob_alloc_tag_2rat = 0;
    rob_alloc_dst_addr_2rat = 0;
    rob_alloc_dst_wen_2rat = 0;
    commit_en = 0;
    rob_commit_tag = 0;
    rob_commit_dst_addr_2rat = 0;
    rob_commit_br_taken = 0;
    rob_commit_exp_en = 0;
  endtask

  task automatic alloc(input int dst, input int tag);
    allocate_en = 1;
    rob_alloc_dst_wen_2rat = 1;
    rob_alloc_dst_addr_2rat = 5'(dst);
    rob_alloc_tag_2rat = 5'(tag);
  endtask

  task automatic commit(input int dst, input int tag);
    commit_en = 1;
    rob_commit_dst_addr_2rat = 5'(dst);
    rob_commit_tag = 5'(tag);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("rs1_valid", int'(rs1_rat_valid), int'(m_valid[rs1_addr]));
      if (m_valid[rs1_addr])
        check("rs1_paddr", int'(rs1_Paddr), m_tag[rs1_addr]);
      check("rs2_valid", int'(rs2_rat_valid), int'(m_valid[rs2_addr]));
      if (m_valid[rs2_addr])
        check("rs2_paddr", int'(rs2_Paddr), m_tag[rs2_addr]);
      check("rat_flush", int'(rat_flush), int'(m_flush));
      check("live_count", int'(live_count), live_model());
    end
  end

  initial begin
    idle();
    rs1_addr = 0;
    rs2_addr = 0;
    rst = 1;
    cycle();
    chk_on = 1;
    idle();
    rs1_addr = 5;
    rs2_addr = 0;
    #3;
    check("rst_rs1_valid", int'(rs1_rat_valid), 0);
    check("rst_rs2_valid", int'(rs2_rat_valid), 0);
    check("rst_live", int'(live_count), 0);
    check("rst_flush", int'(rat_flush), 0);

    alloc(5, 3);
    #3 check("same_cycle_invisible", int'(rs1_rat_valid), 0);
    cycle();
    idle();
    #3;
    check("x5_valid", int'(rs1_rat_valid), 1);
    check("x5_tag3", int'(rs1_Paddr), 3);
    check("live_1", int'(live_count), 1);

    alloc(5, 7);
    cycle();
    idle();
    commit(5, 3);
    cycle();
    idle();
    #3;
    check("stale_commit_valid", int'(rs1_rat_valid), 1);
    check("stale_commit_tag7", int'(rs1_Paddr), 7);
    commit(5, 7);
    #3 check("release_cycle_valid", int'(rs1_rat_valid), 1);
    cycle();
    idle();
    #3;
    check("released_valid", int'(rs1_rat_valid), 0);
    check("released_live", int'(live_count), 0);

    alloc(6, 4);
    cycle();
    idle();
    alloc(6, 9);
    commit(6, 4);
    cycle();
    idle();
    rs1_addr = 6;
    #3;
    check("x6_rename_wins", int'(rs1_rat_valid), 1);
    check("x6_tag9", int'(rs1_Paddr), 9);
    check("x6_live", int'(live_count), 1);

    alloc(1, 1);
    cycle();
    alloc(2, 2);
    cycle();
    alloc(3, 3);
    cycle();
    idle();
    #3 check("pre_flush_live", int'(live_count), 4);
    commit(1, 1);
    rob_commit_br_taken = 1;
    alloc(4, 10);
    cycle();
    idle();
    rs1_addr = 1;
    rs2_addr = 4;
    #3;
    check("flush_pulse", int'(rat_flush), 1);
    check("flush_live", int'(live_count), 0);
    check("flush_x1", int'(rs1_rat_valid), 0);
    check("flush_x4", int'(rs2_rat_valid), 0);
    cycle();
    rs1_addr = 2;
    rs2_addr = 3;
    #3;
    check("flush_one_cycle", int'(rat_flush), 0);
    check("flush_x2", int'(rs1_rat_valid), 0);
    check("flush_x3", int'(rs2_rat_valid), 0);

    alloc(0, 5);
    cycle();
    idle();
    rs1_addr = 0;
    #3;
    check("x0_never", int'(rs1_rat_valid), 0);
    check("x0_live", int'(live_count), 0);

    alloc(7, 1);
    cycle();
    idle();
    commit(7, 1);
    rob_commit_exp_en = 1;
    rst = 1;
    cycle();
    idle();
    #3 check("rst_beats_flush", int'(rat_flush), 0);
    commit(2, 2);
    rob_commit_exp_en = 1;
    cycle();
    idle();
    rst = 1;
    cycle();
    idle();
    #3 check("rst_during_flush", int'(rat_flush), 0);

    for (int n = 0; n < 3000; n++) begin
      int d;
      idle();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) != 0) begin
        allocate_en = 1;
        rob_alloc_dst_wen_2rat = ($urandom_range(0, 7) != 0);
        rob_alloc_dst_addr_2rat = $urandom_range(0, 1) ?
          5'($urandom_range(0, 7)) : 5'($urandom);
        rob_alloc_tag_2rat = 5'($urandom);
      end
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        commit_en = 1;
        rob_commit_dst_addr_2rat = 5'(d);
        rob_commit_tag = $urandom_range(0, 3) != 0 ? 5'(m_tag[d]) : 5'($urandom);
        rob_commit_br_taken = ($urandom_range(0, 40) == 0);
        rob_commit_exp_en = ($urandom_range(0, 60) == 0);
      end
      rs1_addr = 5'($urandom);
      rs2_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      cycle();
    end

    idle();
    cycle();
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
